// File: rtl/fetch_pc_gen.sv
// Fetch PC generator: PC register with redirect/stall priority and a
// 16-entry direct-mapped BTB with 2-bit saturating counters.
module fetch_pc_gen (
    input  logic        clk,
    input  logic        rst,
    input  logic        icache_stall,
    input  logic        dcache_stall,
    input  logic        hold,
    input  logic        predict_fail,
    input  logic [31:0] correct_pc,
    input  logic        update_en,
    input  logic [31:0] update_pc,
    input  logic [31:0] update_target,
    input  logic        update_taken,
    output logic [31:0] pc_out,
    output logic        predict_out,
    output logic [31:0] predict_pc_out
);
    localparam int DEPTH = 16;

    logic [31:0] pc;

    logic        btb_valid  [DEPTH];
    logic [25:0] btb_tag    [DEPTH];
    logic [31:0] btb_target [DEPTH];
    logic [1:0]  btb_ctr    [DEPTH];

    logic [3:0]  look_idx;
    logic        look_hit;
    logic        stall;

    logic [3:0]  upd_idx;
    logic        upd_hit;
    logic        upd_alloc;
    logic        upd_tgt_we;
    logic        upd_ctr_we;
    logic [1:0]  upd_ctr;

    logic        unused_bits;

    assign unused_bits = ^update_pc[1:0];

    // Lookup reads the registered arrays, so a same-cycle update is
    // only seen from the following cycle.
    assign look_idx = pc[5:2];
    assign look_hit = btb_valid[look_idx]
                      && (btb_tag[look_idx] == pc[31:6]);

    assign pc_out         = pc;
    assign predict_out    = look_hit & btb_ctr[look_idx][1];
    assign predict_pc_out = predict_out ? btb_target[look_idx]
                                        : pc + 32'd4;

    assign stall = icache_stall | dcache_stall | hold;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= '0;
        end else if (predict_fail) begin
            pc <= correct_pc;
        end else if (!stall) begin
            pc <= predict_pc_out;
        end
    end

    assign upd_idx = update_pc[5:2];
    assign upd_hit = btb_valid[upd_idx]
                     && (btb_tag[upd_idx] == update_pc[31:6]);

    always_comb begin
        upd_alloc  = 1'b0;
        upd_tgt_we = 1'b0;
        upd_ctr_we = 1'b0;
        upd_ctr    = btb_ctr[upd_idx];
        if (update_en) begin
            if (update_taken) begin
                upd_tgt_we = 1'b1;
                upd_ctr_we = 1'b1;
                if (upd_hit) begin
                    if (btb_ctr[upd_idx] != 2'b11) begin
                        upd_ctr = btb_ctr[upd_idx] + 2'd1;
                    end
                end else begin
                    upd_alloc = 1'b1;
                    upd_ctr   = 2'b10;
                end
            end else if (upd_hit) begin
                upd_ctr_we = 1'b1;
                if (btb_ctr[upd_idx] != 2'b00) begin
                    upd_ctr = btb_ctr[upd_idx] - 2'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                btb_valid[i] <= 1'b0;
                btb_ctr[i]   <= 2'b01;
            end
        end else begin
            if (upd_alloc) begin
                btb_valid[upd_idx] <= 1'b1;
            end
            if (upd_ctr_we) begin
                btb_ctr[upd_idx] <= upd_ctr;
            end
        end
    end

    // Tags and targets carry no reset; valid bits guard them.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (upd_alloc) begin
                btb_tag[upd_idx] <= update_pc[31:6];
            end
            if (upd_tgt_we) begin
                btb_target[upd_idx] <= update_target;
            end
        end
    end

endmodule

// File: doc/fetch_pc_gen.md
FETCH_PC_GEN -- requirements
Module: fetch_pc_gen

Interface
REQ-001 SHALL use reset rst, synchronous, active-high; clock clk.
REQ-002 SHALL have ports, one per line as: name  direction  width  meaning.
  clk  in  1  clock, rising edge
  rst  in  1  synchronous active-high reset
  icache_stall  in  1  instruction cache miss in progress
  dcache_stall  in  1  data cache miss; whole pipeline frozen
  hold  in  1  load-use hazard; fetch frozen
  predict_fail  in  1  EX-stage misprediction; redirect fetch
  correct_pc  in  32  redirect target, valid with predict_fail
  update_en  in  1  resolved branch/jump report from EX
  update_pc  in  32  PC of the resolved branch
  update_target  in  32  resolved taken target
  update_taken  in  1  resolved direction
  pc_out  out  32  current fetch address to icache and IF/ID pc input
  predict_out  out  1  predicted-taken flag for instruction at pc_out
  predict_pc_out  out  32  predicted next PC for instruction at pc_out

Function
REQ-003 SHALL hold a 32-bit PC register; pc_out equals that register combinationally.
REQ-004 SHALL update the PC each rising edge with this priority: rst -> 0; predict_fail -> correct_pc; (icache_stall | dcache_stall | hold) -> unchanged; otherwise -> predict_pc_out.
REQ-005 SHALL let predict_fail override every stall; repeated predict_fail with the same correct_pc (frozen EX under dcache_stall) SHALL be idempotent.
REQ-006 SHALL contain a 16-entry direct-mapped BTB: index = pc[5:2], tag = pc[31:6], plus a valid bit, a 32-bit target and a 2-bit saturating counter per entry.
REQ-007 SHALL compute lookup combinationally from the PC register: hit = valid & tag match; predict_out = hit & counter[1].
REQ-008 SHALL drive predict_pc_out = BTB target when predict_out = 1, else pc_out + 4, modulo 2^32 (0xFFFFFFFC + 4 = 0x00000000).
REQ-009 SHALL, on update_en with update_taken = 1 and a hit at update_pc, increment the counter saturating at 2'b11 and overwrite the target with update_target.
REQ-010 SHALL, on update_en with update_taken = 1 and a miss, allocate the entry: valid = 1, tag from update_pc, target = update_target, counter = 2'b10; any previous occupant is evicted.
REQ-011 SHALL, on update_en with update_taken = 0 and a hit, decrement the counter saturating at 2'b00, leaving target and valid unchanged; on a miss, SHALL not change the BTB.
REQ-012 SHALL apply BTB updates regardless of any stall or of predict_fail in the same cycle.
REQ-013 SHALL return pre-update (old) contents when a lookup and an update hit the same index in the same cycle; the new value is visible from the next cycle.
REQ-014 SHALL keep predict_out and predict_pc_out consistent with pc_out in every cycle, including stalled cycles, so that IF/ID captures aligned pc/prediction.

Reset
REQ-015 SHALL, on rst, set PC = 0x00000000, all BTB valid bits = 0, all counters = 2'b01; targets and tags need not be cleared.
REQ-016 SHALL, in the cycle after reset, output pc_out = 0, predict_out = 0, predict_pc_out = 4.
REQ-017 SHALL let rst asserted mid-operation (stall, redirect, update pending) override everything and discard a concurrent update_en.

Verification
REQ-018 Sequential fetch: reset, no stalls, 4 cycles -> pc_out = 0,4,8,12; predict_out = 0 throughout.
REQ-019 Stall priority: at pc = 0x10, assert icache_stall 3 cycles, then in the next cycle dcache_stall and predict_fail(correct_pc = 0x80) together -> pc_out held at 0x10 for 3 cycles, then 0x80.
REQ-020 Train/predict: update_en, update_pc = 0x20, target = 0x100, taken = 1 -> on the next fetch of 0x20, predict_out = 1 and predict_pc_out = 0x100, and the following pc_out = 0x100.
REQ-021 Counter saturation: from REQ-020, taken x3 then not-taken x1 -> still predicts taken; not-taken x2 more -> predict_out = 0, predict_pc_out = 0x24.
REQ-022 Alias/evict: entry for 0x20 valid; taken update at 0x60 (same index) -> 0x20 misses (predict_pc_out = 0x24), 0x60 hits with the new target; not-taken update at an unseen PC leaves the BTB unchanged.
REQ-023 Wrap and same-cycle update: PC = 0xFFFFFFFC -> next pc_out = 0; an update to the current index in the lookup cycle -> old prediction that cycle, new prediction on the next access.
